// File: rtl/uart_pkg.sv
// Shared state encoding and frame constants for the button-driven UART transmitter.
// Frame layout: one start bit, DATA_BITS data bits LSB first, one stop bit.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/btn_uart_tx_if.sv
// Byte-side handshake between the button/switch capture logic and the UART transmitter.
// Master drives the strobe and byte; the transmitter reports FIFO status back.
interface btn_uart_tx_if;
    import uart_pkg::*;

    logic                 dataRdy;
    logic [DATA_BITS-1:0] data;
    logic                 fifoFull;
    logic                 overflow;

    modport master (output dataRdy, data, input fifoFull, overflow);
    modport slave  (input dataRdy, data, output fifoFull, overflow);

endinterface

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO: dout shows the head whenever empty is low.
// Pointers carry one extra wrap bit so full and empty fall out of a plain compare.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW:0]          r_wrPtr;
    logic [AW:0]          r_rdPtr;
    logic                 w_doPush;
    logic                 w_doPop;

    assign empty = (r_wrPtr == r_rdPtr);
    assign full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign dout  = r_mem[r_rdPtr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push while full is still taken.
    assign w_doPop  = pop && !empty;
    assign w_doPush = push && (!full || w_doPop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + (AW+1)'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/btn_uart_tx.sv
// Queues button-strobed bytes and serialises them as 8N1 onto a registered TX line.
// STOP pops straight into START when more bytes wait, so bursts go out without idle gaps.
module btn_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    btn_uart_tx_if.slave        byteIf,
    output logic                tx,
    output logic                busy
);

    localparam int              BW        = $clog2(CLKS_PER_BIT);
    localparam int              IW        = $clog2(DATA_BITS);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(DATA_BITS - 1);

    uart_state_t          r_state;
    uart_state_t          w_nextState;
    logic [BW-1:0]        r_baudCnt;
    logic [BW-1:0]        w_baudNext;
    logic [IW-1:0]        r_bitIdx;
    logic [IW-1:0]        w_bitIdxNext;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shiftNext;
    logic                 r_tx;
    logic                 w_txNext;
    logic                 r_overflow;
    logic                 w_pop;
    logic                 w_bitEnd;
    logic                 w_fifoEmpty;
    logic                 w_fifoFull;
    logic [DATA_BITS-1:0] w_fifoDout;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (byteIf.dataRdy),
        .din   (byteIf.data),
        .pop   (w_pop),
        .dout  (w_fifoDout),
        .full  (w_fifoFull),
        .empty (w_fifoEmpty)
    );

    assign w_bitEnd        = (r_baudCnt == BAUD_LAST);
    assign tx              = r_tx;
    assign busy            = (r_state != IDLE) || !w_fifoEmpty;
    assign byteIf.fifoFull = w_fifoFull;
    assign byteIf.overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_baudCnt  <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_baudCnt  <= w_baudNext;
            r_bitIdx   <= w_bitIdxNext;
            r_shift    <= w_shiftNext;
            r_tx       <= w_txNext;
            r_overflow <= byteIf.dataRdy && w_fifoFull && !w_pop;
        end
    end

    // TX is computed from the next state so the line switches on the same edge as the state.
    always_comb begin
        w_nextState  = r_state;
        w_baudNext   = w_bitEnd ? '0 : r_baudCnt + BW'(1);
        w_bitIdxNext = r_bitIdx;
        w_shiftNext  = r_shift;
        w_pop        = 1'b0;
        w_txNext     = 1'b1;

        case (r_state)
            IDLE: begin
                w_baudNext = '0;
                if (!w_fifoEmpty) begin
                    w_pop       = 1'b1;
                    w_shiftNext = w_fifoDout;
                    w_nextState = START;
                end
            end
            START: begin
                if (w_bitEnd) begin
                    w_nextState  = DATA;
                    w_bitIdxNext = '0;
                end
            end
            DATA: begin
                if (w_bitEnd) begin
                    w_shiftNext = r_shift >> 1;
                    if (r_bitIdx == IDX_LAST) begin
                        w_nextState = STOP;
                    end else begin
                        w_bitIdxNext = r_bitIdx + IW'(1);
                    end
                end
            end
            STOP: begin
                if (w_bitEnd) begin
                    if (!w_fifoEmpty) begin
                        w_pop       = 1'b1;
                        w_shiftNext = w_fifoDout;
                        w_nextState = START;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase

        case (w_nextState)
            START:   w_txNext = 1'b0;
            DATA:    w_txNext = w_shiftNext[0];
            default: w_txNext = 1'b1;
        endcase
    end

endmodule
